// File: rtl/line_ram_ctrl_pkg.sv
// line_ram_pkg: shared types and helpers for the debayer line-RAM controller.
package line_ram_pkg;

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   localparam int MAX_MEM = 64;

   function automatic logic [MAX_MEM-1:0] one_hot(input int unsigned idx);
      return MAX_MEM'(1) << idx;
   endfunction

   function automatic int unsigned mod_inc(input int unsigned v, input int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/line_ram_ctrl_if.sv
// line_ram_ctrl_if: pixel stream in, RAM bank controls and read-side status out.
interface line_ram_ctrl_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 45,
   parameter int MEM_NUM    = 4
);
   localparam int SEL_W = $clog2(MEM_NUM);

   logic                  frame_start_i;
   logic                  pixel_valid_i;
   logic [DATA_WIDTH-1:0] pixel_data_i;
   logic                  line_end_i;
   logic [MEM_NUM-1:0]    ram_write_enable_o;
   logic [MEM_NUM-1:0]    ram_read_enable_o;
   logic [ADDR_WIDTH-1:0] ram_write_address_o;
   logic [ADDR_WIDTH-1:0] ram_read_address_o;
   logic [DATA_WIDTH-1:0] ram_data_o;
   logic                  rd_valid_o;
   logic [SEL_W-1:0]      oldest_sel_o;
   logic [SEL_W-1:0]      cur_sel_o;
   logic                  lines_ready_o;
   logic                  overflow_o;

   modport master (
      output frame_start_i, pixel_valid_i, pixel_data_i, line_end_i,
      input  ram_write_enable_o, ram_read_enable_o, ram_write_address_o,
             ram_read_address_o, ram_data_o, rd_valid_o, oldest_sel_o,
             cur_sel_o, lines_ready_o, overflow_o
   );

   modport slave (
      input  frame_start_i, pixel_valid_i, pixel_data_i, line_end_i,
      output ram_write_enable_o, ram_read_enable_o, ram_write_address_o,
             ram_read_address_o, ram_data_o, rd_valid_o, oldest_sel_o,
             cur_sel_o, lines_ready_o, overflow_o
   );

endinterface

// File: rtl/line_ram_ctrl.sv
// line_ram_ctrl: writes each line into one RAM in rotation and reads the
// previous MEM_NUM-1 lines at the same column for the debayer window.
module line_ram_ctrl
   import line_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 45,
   parameter int MEM_NUM    = 4
) (
   input logic           clk_i,
   input logic           rst_i,
   line_ram_ctrl_if.slave bus
);
   localparam int SEL_W = $clog2(MEM_NUM);

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] col;
   logic [SEL_W-1:0]      wr_sel, sel_nx, filled, old_d, cur_d;
   logic                  drop, overflow, rd_req;
   logic                  active, acc, le, last_fill, streaming;
   logic [MEM_NUM-1:0]    wr_oh;

   // frame_start wins over any pixel or line_end in the same cycle
   assign active    = state != IDLE && !bus.frame_start_i;
   assign acc       = active && bus.pixel_valid_i && !drop;
   assign le        = active && bus.pixel_valid_i && bus.line_end_i;
   assign streaming = state == STREAM;
   assign wr_oh     = MEM_NUM'(one_hot(32'(wr_sel)));
   assign sel_nx    = SEL_W'(mod_inc(32'(wr_sel), MEM_NUM));
   assign last_fill = filled == SEL_W'(MEM_NUM - 2);

   always_comb begin
      state_nx = bus.frame_start_i ? FILL :
                 (state == FILL && le && last_fill) ? STREAM : state;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col      <= '0;
         wr_sel   <= '0;
         filled   <= '0;
         overflow <= 1'b0;
         drop     <= 1'b0;
      end else if (bus.frame_start_i) begin
         col      <= '0;
         wr_sel   <= '0;
         filled   <= '0;
         overflow <= 1'b0;
         drop     <= 1'b0;
      end else if (le) begin
         col      <= '0;
         wr_sel   <= sel_nx;
         filled   <= (filled == SEL_W'(MEM_NUM - 1)) ? filled : filled + 1'b1;
         drop     <= 1'b0;
      end else if (acc) begin
         col <= col + 1'b1;
         // last column written without line_end: drop the rest of this line
         if (col == '1) begin
            overflow <= 1'b1;
            drop     <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus.ram_write_enable_o  <= '0;
         bus.ram_read_enable_o   <= '0;
         bus.ram_write_address_o <= '0;
         bus.ram_read_address_o  <= '0;
         bus.ram_data_o          <= '0;
         rd_req                  <= 1'b0;
         bus.rd_valid_o          <= 1'b0;
         old_d                   <= '0;
         cur_d                   <= '0;
         bus.oldest_sel_o        <= '0;
         bus.cur_sel_o           <= '0;
      end else begin
         bus.ram_write_enable_o <= acc ? wr_oh : '0;
         bus.ram_read_enable_o  <= (acc && streaming) ? ~wr_oh : '0;
         if (acc) begin
            bus.ram_write_address_o <= col;
            bus.ram_data_o          <= bus.pixel_data_i;
            old_d                   <= sel_nx;
            cur_d                   <= wr_sel;
         end
         if (acc && streaming) bus.ram_read_address_o <= col;
         // one extra stage covers the RAM read latency; not cancelled by frame_start
         rd_req         <= acc && streaming;
         bus.rd_valid_o <= rd_req;
         if (rd_req) begin
            bus.oldest_sel_o <= old_d;
            bus.cur_sel_o    <= cur_d;
         end
      end
   end

   assign bus.lines_ready_o = streaming;
   assign bus.overflow_o    = overflow;

endmodule

// File: tb/tb_line_ram_ctrl.sv
// tb_line_ram_ctrl: directed checks of fill, stream, wrap, overflow,
// frame restart and asynchronous reset with MEM_NUM=4, ADDR_WIDTH=3.
module tb_line_ram_ctrl;
   localparam int AW = 3;
   localparam int DW = 45;
   localparam int MN = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   line_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_NUM(MN)) bus ();

   line_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_NUM(MN)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );

   function automatic logic [DW-1:0] pd(input int l, input int c);
      return DW'(l * 16 + c + 45'h1000_0000_00);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic fs, input logic pv, input logic le, input logic [DW-1:0] d);
      bus.frame_start_i = fs;
      bus.pixel_valid_i = pv;
      bus.line_end_i    = le;
      bus.pixel_data_i  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".we"}, 64'(bus.ram_write_enable_o), 64'h0);
      chk({tag, ".re"}, 64'(bus.ram_read_enable_o), 64'h0);
      chk({tag, ".waddr"}, 64'(bus.ram_write_address_o), 64'h0);
      chk({tag, ".raddr"}, 64'(bus.ram_read_address_o), 64'h0);
      chk({tag, ".data"}, 64'(bus.ram_data_o), 64'h0);
      chk({tag, ".rd_valid"}, 64'(bus.rd_valid_o), 64'h0);
      chk({tag, ".oldest"}, 64'(bus.oldest_sel_o), 64'h0);
      chk({tag, ".cur"}, 64'(bus.cur_sel_o), 64'h0);
      chk({tag, ".ready"}, 64'(bus.lines_ready_o), 64'h0);
      chk({tag, ".ovf"}, 64'(bus.overflow_o), 64'h0);
   endtask

   initial begin
      rst = 1'b1;
      bus.frame_start_i = 1'b0;
      bus.pixel_valid_i = 1'b0;
      bus.line_end_i    = 1'b0;
      bus.pixel_data_i  = '0;
      #3;
      chk_zero("reset");
      #9 rst = 1'b0;

      // pixels before frame_start are ignored
      step(0, 1, 0, pd(0, 0));
      chk("idle.we", 64'(bus.ram_write_enable_o), 64'h0);
      step(1, 0, 0, '0);
      chk("fs.ready", 64'(bus.lines_ready_o), 64'h0);

      for (int l = 0; l < 3; l++) begin
         for (int c = 0; c < 8; c++) begin
            step(0, 1, c == 7, pd(l, c));
            chk("fill.we", 64'(bus.ram_write_enable_o), 64'(4'b0001 << l));
            chk("fill.waddr", 64'(bus.ram_write_address_o), 64'(c));
            chk("fill.data", 64'(bus.ram_data_o), 64'(pd(l, c)));
            chk("fill.re", 64'(bus.ram_read_enable_o), 64'h0);
            chk("fill.ready", 64'(bus.lines_ready_o), 64'(l == 2 && c == 7));
         end
      end

      for (int l = 3; l < 5; l++) begin
         for (int c = 0; c < 8; c++) begin
            int pl;
            logic rv;
            step(0, 1, c == 7, pd(l, c));
            chk("strm.we", 64'(bus.ram_write_enable_o), 64'(4'b0001 << (l % 4)));
            chk("strm.re", 64'(bus.ram_read_enable_o), 64'(~(4'b0001 << (l % 4)) & 4'hf));
            chk("strm.raddr", 64'(bus.ram_read_address_o), 64'(c));
            chk("strm.waddr", 64'(bus.ram_write_address_o), 64'(c));
            rv = (l == 4) || (c > 0);
            pl = (c == 0) ? l - 1 : l;
            chk("strm.rd_valid", 64'(bus.rd_valid_o), 64'(rv));
            if (rv) begin
               chk("strm.oldest", 64'(bus.oldest_sel_o), 64'((pl + 1) % 4));
               chk("strm.cur", 64'(bus.cur_sel_o), 64'(pl % 4));
            end
         end
      end

      step(0, 0, 0, '0);
      chk("tail.rd_valid", 64'(bus.rd_valid_o), 64'h1);
      chk("tail.oldest", 64'(bus.oldest_sel_o), 64'h1);
      chk("tail.cur", 64'(bus.cur_sel_o), 64'h0);
      chk("tail.we", 64'(bus.ram_write_enable_o), 64'h0);
      step(0, 0, 0, '0);
      chk("tail2.rd_valid", 64'(bus.rd_valid_o), 64'h0);

      // 10-pixel line into RAM 1: cols 0..7 written, rest dropped
      for (int i = 0; i < 10; i++) begin
         step(0, 1, i == 9, pd(5, i));
         chk("ovf.we", 64'(bus.ram_write_enable_o), 64'(i < 8 ? 4'b0010 : 4'b0000));
         chk("ovf.flag", 64'(bus.overflow_o), 64'(i >= 7));
         chk("ovf.rd_valid", 64'(bus.rd_valid_o), 64'(i >= 1 && i <= 8));
         if (i < 8) chk("ovf.waddr", 64'(bus.ram_write_address_o), 64'(i));
      end
      step(0, 1, 0, pd(6, 0));
      chk("post.we", 64'(bus.ram_write_enable_o), 64'h4);
      chk("post.waddr", 64'(bus.ram_write_address_o), 64'h0);
      chk("post.ovf", 64'(bus.overflow_o), 64'h1);
      chk("post.rd_valid", 64'(bus.rd_valid_o), 64'h0);
      step(0, 1, 0, pd(6, 1));
      chk("post2.waddr", 64'(bus.ram_write_address_o), 64'h1);
      chk("post2.rd_valid", 64'(bus.rd_valid_o), 64'h1);

      // frame_start with a pixel in STREAM: pixel dropped, in-flight read completes
      step(1, 1, 0, pd(7, 7));
      chk("sim.we", 64'(bus.ram_write_enable_o), 64'h0);
      chk("sim.re", 64'(bus.ram_read_enable_o), 64'h0);
      chk("sim.ready", 64'(bus.lines_ready_o), 64'h0);
      chk("sim.ovf", 64'(bus.overflow_o), 64'h0);
      chk("sim.rd_valid", 64'(bus.rd_valid_o), 64'h1);
      chk("sim.oldest", 64'(bus.oldest_sel_o), 64'h3);
      chk("sim.cur", 64'(bus.cur_sel_o), 64'h2);
      step(0, 1, 0, pd(8, 0));
      chk("sim2.we", 64'(bus.ram_write_enable_o), 64'h1);
      chk("sim2.waddr", 64'(bus.ram_write_address_o), 64'h0);
      chk("sim2.data", 64'(bus.ram_data_o), 64'(pd(8, 0)));
      chk("sim2.re", 64'(bus.ram_read_enable_o), 64'h0);
      chk("sim2.rd_valid", 64'(bus.rd_valid_o), 64'h0);
      step(0, 1, 0, pd(8, 1));

      // reset between clock edges
      #2 rst = 1'b1;
      #1 chk_zero("arst");
      #2 rst = 1'b0;
      step(0, 1, 0, pd(9, 9));
      chk("arst.idle_we", 64'(bus.ram_write_enable_o), 64'h0);
      step(1, 0, 0, '0);
      step(0, 1, 0, pd(9, 0));
      chk("arst.we", 64'(bus.ram_write_enable_o), 64'h1);
      chk("arst.waddr", 64'(bus.ram_write_address_o), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_ram_ctrl.md
# line_ram_ctrl

Sequencing controller for the debayer line-RAM bank (`dual_port_ram_wrapper`, MEM_NUM lines).
- Takes the incoming pixel stream and writes each line into one RAM in rotation.
- At the same column it reads the previous MEM_NUM-1 lines from the other RAMs.
- Reports which RAM holds the oldest line, so the debayer window can be assembled.
- Sits between the pixel unpacker and the debayer filter; it owns all enables, addresses and write data of the RAM bank.

## Interface
Parameters:
- ADDR_WIDTH, 11, column address width; max line length 2**ADDR_WIDTH pixels
- DATA_WIDTH, 45, RAM word width
- MEM_NUM, 4, number of line RAMs (≥2); SEL_W = $clog2(MEM_NUM)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- frame_start_i  in  1  start of frame pulse
- pixel_valid_i  in  1  pixel_data_i valid this cycle
- pixel_data_i  in  DATA_WIDTH  pixel word
- line_end_i  in  1  qualifies last pixel of a line (only meaningful with pixel_valid_i)
- ram_write_enable_o  out  MEM_NUM  one-hot write enable
- ram_read_enable_o  out  MEM_NUM  read enables
- ram_write_address_o  out  ADDR_WIDTH  write column
- ram_read_address_o  out  ADDR_WIDTH  read column
- ram_data_o  out  DATA_WIDTH  write data
- rd_valid_o  out  1  RAM read data valid this cycle
- oldest_sel_o  out  SEL_W  RAM index of oldest line, aligned with rd_valid_o
- cur_sel_o  out  SEL_W  RAM index being written, aligned with rd_valid_o
- lines_ready_o  out  1  MEM_NUM-1 full lines buffered
- overflow_o  out  1  sticky: line exceeded 2**ADDR_WIDTH pixels

## Operation
- State FSM: IDLE → FILL → STREAM.
  - IDLE: ignore pixels until frame_start_i.
  - frame_start_i: clear col, wr_sel=0, filled=0, overflow; go to FILL.
  - FILL: write only, no reads.
  - On the line_end that makes filled==MEM_NUM-1, go to STREAM.
  - STREAM: write plus read.
- frame_start_i has priority over pixel_valid_i and line_end_i in the same cycle. The pixel in that cycle is dropped and the state restarts at FILL.
- Accepted pixel:
  - ram_write_enable_o = one-hot(wr_sel); address = col; data = pixel_data_i.
  - In STREAM, ram_read_enable_o = ~one-hot(wr_sel) and read address = col.
  - col increments.
- line_end_i with pixel_valid_i:
  - The pixel is written at the current col.
  - Then col←0, wr_sel←(wr_sel+1) mod MEM_NUM, filled saturating-increments to MEM_NUM-1.
- oldest_sel = (wr_sel+1) mod MEM_NUM; cur_sel = wr_sel. Both are sampled with the accepted pixel and delayed to align with rd_valid_o.
- Overflow: pixel arrives while col == 2**ADDR_WIDTH-1 without line_end_i.
  - That pixel is written; overflow_o sets.
  - Further pixels of that line produce no enables until line_end_i.
  - line_end_i in the dropped region still advances the line.
  - overflow_o clears only on frame_start_i or reset.
- line_end_i without pixel_valid_i is ignored.
- lines_ready_o = (state == STREAM).

## Timing
- All RAM-side outputs are registered; latency pixel_valid_i → ram_*_o = 1 cycle.
- RAM read latency is 1 cycle, so rd_valid_o asserts 2 cycles after an accepted STREAM pixel. Exactly one rd_valid_o pulse per accepted STREAM pixel.
- No backpressure: one pixel per cycle is sustained indefinitely.
- Reset values:
  - State IDLE.
  - All enables 0; addresses 0; ram_data_o 0.
  - rd_valid_o 0, oldest_sel_o 0, cur_sel_o 0, lines_ready_o 0, overflow_o 0.
- Reset mid-line: everything returns to reset values immediately (async). RAM contents are irrelevant afterwards.
- frame_start_i mid-line:
  - Enables go low the next cycle.
  - An in-flight rd_valid_o (already issued read) still completes.

## Structure
- `line_ram_pkg`:
  - state enum (IDLE, FILL, STREAM)
  - function for one-hot of SEL_W index
  - modulo-increment helper for wr_sel
- Single module; no sub-module required.
- Parent instantiates `line_ram_ctrl` plus `dual_port_ram_wrapper` with matching parameters; ram_data_o feeds the wrapper's shared write data.

## Test plan
All scenarios use MEM_NUM=4, ADDR_WIDTH=3, lines of 8 pixels unless stated.
1. **Fill:** frame_start, then 3 lines.
   - Write enables 0001, 0010, 0100 in turn; addresses 0..7; no read enables.
   - lines_ready_o rises the cycle after the 3rd line_end.
2. **Stream:** 4th line, pixel p at col c.
   - Write enable 1000, read enable 0111 at address c one cycle later.
   - rd_valid_o two cycles after input; oldest_sel_o=0, cur_sel_o=3.
3. **Wrap:** 5th line.
   - Write enable 0001, read enable 1110, oldest_sel_o=1.
4. **Overflow:** 10-pixel line with line_end on the 10th pixel.
   - Writes at cols 0..7 only; overflow_o=1 from the 8th pixel.
   - Next line starts at col 0 in the next RAM.
5. **Simultaneous:** frame_start_i together with pixel_valid_i in STREAM.
   - Pixel dropped; state FILL; wr_sel=0; overflow_o cleared.
   - Next pixel is written to RAM 0 at col 0.
6. **Async reset:** rst_i pulse mid-line, not clock-aligned.
   - All outputs reach reset values without a clock edge.
   - Pixels are ignored until frame_start_i.
